sha_msg_scheduler: RTL

Parametrised SHA-2 message-schedule generator: accepts the 16 message words of one block per channel and streams the full schedule W[0..R-1] for each channel. Supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds), and interleaves CH independent blocks word by word. It sits between the block buffer and the compression-round core. Both sides use valid/ready handshakes with output backpressure.

---
 rtl/sha_msg_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sha_msg_scheduler.sv
// -----------------------------------------------------------------------------
// sha_msg_scheduler
//
// SHA-2 message-schedule generator. It accepts the 16 message words of one
// block for each of CH interleaved channels. It then streams the full schedule
// W[0..R-1] of every channel, in slot order s = t*CH + c.
//   WORD_W = 32 -> SHA-256 (R = 64), WORD_W = 64 -> SHA-512 (R = 80).
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      pulse in IDLE starts a batch (ignored while busy)
//   in_valid_i   data_i holds a message word
//   in_ready_o   message word accepted when in_valid_i & in_ready_o
//   data_i       message word
//   out_valid_o  data_o holds a schedule word
//   out_ready_i  consumer accepts when out_valid_o & out_ready_i
//   data_o       schedule word W[idx_o] of channel ch_o
//   idx_o        round index 0..R-1
//   ch_o         channel index 0..CH-1
//   last_o       final word of the batch (idx_o = R-1, ch_o = CH-1)
//   busy_o       high while loading or expanding
// -----------------------------------------------------------------------------
module sha_msg_scheduler #(
  parameter int WORD_W = 32,
  parameter int CH     = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] data_o,
  output logic [6:0]        idx_o,
  output logic [2:0]        ch_o,
  output logic              last_o,
  output logic              busy_o
);

  localparam int unsigned R     = (WORD_W == 64) ? 80 : 64;
  localparam int unsigned NWIN  = 16 * CH;
  localparam int unsigned TOTAL = R * CH;
  localparam int unsigned CNT_W = $clog2(TOTAL);
  localparam int unsigned CH_SH = $clog2(CH);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(NWIN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CH_MASK   = CNT_W'(CH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] win_q [NWIN];
  logic [WORD_W-1:0] win_d [NWIN];
  logic [WORD_W-1:0] data_q, data_d;
  logic [6:0]        idx_q, idx_d;
  logic [2:0]        ch_q, ch_d;
  logic              last_q, last_d;
  logic              out_valid_q, out_valid_d;

  logic              adv;
  logic              in_ready;
  logic              produce;
  logic              new_last;
  logic [WORD_W-1:0] new_word;
  logic [WORD_W-1:0] gen_word;

  always_comb begin
    adv      = !out_valid_q | out_ready_i;
    in_ready = (state_q == S_LOAD) & adv;
    // win[k] holds slot s-1-k, so same-channel W[t-n] sits at win[n*CH-1].
    gen_word = sig1(win_q[2*CH-1]) + win_q[7*CH-1] +
               sig0(win_q[15*CH-1]) + win_q[NWIN-1];

    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    data_d      = data_q;
    idx_d       = idx_q;
    ch_d        = ch_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    produce     = 1'b0;
    new_last    = 1'b0;
    new_word    = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid_i && in_ready) begin
          produce  = 1'b1;
          new_word = data_i;
          if (cnt_q == LOAD_LAST) state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (adv) begin
          produce  = 1'b1;
          new_word = gen_word;
          new_last = (cnt_q == CNT_LAST);
          if (new_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (produce) begin
      win_d[0] = new_word;
      for (int unsigned i = 1; i < NWIN; i++) win_d[i] = win_q[i-1];
      data_d      = new_word;
      idx_d       = 7'(cnt_q >> CH_SH);
      ch_d        = 3'(cnt_q & CH_MASK);
      last_d      = new_last;
      out_valid_d = 1'b1;
      cnt_d       = new_last ? '0 : cnt_q + CNT_W'(1);
    end else if (adv) begin
      // Consumed (or empty) with nothing new: let the output drain.
      out_valid_d = 1'b0;
      last_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < NWIN; i++) win_q[i] <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      ch_q        <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign data_o      = data_q;
  assign idx_o       = idx_q;
  assign ch_o        = ch_q;
  assign last_o      = last_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
